mips_mc_control: RTL and testbench
==================================

Name: mips_mc_control

Overview:
- Multi-cycle MIPS main control FSM. It is the initiator side of the register-file and memory write interfaces.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives RegWrite/RegDst/MemtoReg to the register file and all other datapath enables and muxes.
- Consumes only the opcode from the instruction register.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_ADDI, 6'b001000, add-immediate opcode
OP_J, 6'b000010, jump opcode

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op  in  6  IR[31:26], valid from DECODE onward
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
MemtoReg  out  1  regfile write data: 0=ALUOut, 1=MDR
RegDst  out  1  regfile write address: 0=rt, 1=rd
RegWrite  out  1  regfile write enable
ALUSrcA  out  1  ALU A: 0=PC, 1=A reg
ALUSrcB  out  2  ALU B: 00=B reg, 01=4, 10=sext imm, 11=sext imm<<2
ALUOp  out  2  00=add, 01=sub, 10=use funct
PCSource  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
state  out  4  current state code, for debug
instr_done  out  1  high in the last cycle of each instruction
illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported

Behaviour:
- Moore machine. A 4-bit state register changes on posedge clk.
- reset=1 asynchronously forces state to FETCH (0).
- While reset=1, every output is forced to 0 combinationally, including state, instr_done and illegal_op.
- After reset falls, FETCH outputs appear immediately. The first state advance occurs on the first rising edge after deassertion.
- Reset mid-instruction aborts the instruction. No write strobe may be asserted while reset is high.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11. Codes 12-15 go to FETCH on the next edge, with all outputs 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE, on op: LW/SW -> MEMADR; RTYPE -> RTYPEEX; BEQ -> BEQEX; ADDI -> ADDIEX; J -> JEX; any other opcode -> FETCH, with illegal_op=1.
  - MEMADR -> MEMRD if op=LW, else MEMWR.
  - MEMRD -> MEMWB.
  - RTYPEEX -> RTYPEWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX each -> FETCH, with instr_done=1 in that state.
- op is only sampled in DECODE and MEMADR. It is don't-care elsewhere.
- Per-state outputs; any output not listed is 0:
  - FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, PCWrite=1.
  - DECODE: ALUSrcB=11.
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1.
  - MEMWR: MemWrite=1, IorD=1.
  - RTYPEEX: ALUSrcA=1, ALUOp=10.
  - RTYPEWB: RegWrite=1, RegDst=1.
  - BEQEX: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10.
  - ADDIWB: RegWrite=1.
  - JEX: PCWrite=1, PCSource=10.
- Instruction latencies in clocks: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- RegWrite is asserted for exactly one cycle per writing instruction. Writes to register 0 are suppressed by the register file, not here.
- MemRead and MemWrite are never high in the same cycle.
- RegWrite and MemWrite are never high in the same cycle.

Test Plan:
- Hold reset=1 with clk running, then release. Required: all outputs 0 during reset; state=0 with MemRead=IRWrite=PCWrite=1 after release; state=1 after one edge.
- op=100011 (lw). Required: states 0,1,2,3,4,0. RegWrite=1 with MemtoReg=1 and RegDst=0 only in state 4. instr_done high only in state 4.
- op=101011 (sw), then op=000000 (R-type). Required: sw visits 0,1,2,5 with MemWrite=1 and IorD=1 in state 5. R-type visits 0,1,6,7 with ALUOp=10 in state 6, and RegWrite=1 with RegDst=1 in state 7.
- op=000100 (beq), then op=000010 (j). Required: beq visits 0,1,8 with PCWriteCond=1, ALUOp=01, PCSource=01. j visits 0,1,11 with PCWrite=1, PCSource=10. Each takes 3 cycles.
- op=111111 in DECODE. Required: illegal_op=1 for exactly one cycle, next state 0, no RegWrite or MemWrite asserted.
- Assert reset asynchronously mid-edge in state 3 (lw MEMRD). Required: outputs drop to 0 immediately without waiting for clk; state=0 after release; no MEMWB write occurs.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control FSM: walks each instruction through fetch, decode,
// execute, memory and writeback, and drives every datapath enable and mux select.
module mips_mc_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    state_t state_q;
    ctrl_t  ctrl_q;

    function automatic logic is_legal(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
               (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);
    endfunction

    function automatic state_t next_state(input state_t s, input logic [5:0] opcode);
        case (s)
            FETCH:   return DECODE;
            DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) return MEMADR;
                else if (opcode == OP_RTYPE)            return RTYPEEX;
                else if (opcode == OP_BEQ)              return BEQEX;
                else if (opcode == OP_ADDI)             return ADDIEX;
                else if (opcode == OP_J)                return JEX;
                else                                    return FETCH;
            end
            MEMADR:  return (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   return MEMWB;
            RTYPEEX: return RTYPEWB;
            ADDIEX:  return ADDIWB;
            default: return FETCH;
        endcase
    endfunction

    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:   begin c.mem_read = 1'b1; c.ir_write = 1'b1; c.alu_src_b = 2'b01; c.pc_write = 1'b1; end
            DECODE:  begin c.alu_src_b = 2'b11; end
            MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEMRD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
            MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
            MEMWR:   begin c.mem_write = 1'b1; c.iord = 1'b1; c.instr_done = 1'b1; end
            RTYPEEX: begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            RTYPEWB: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1; end
            BEQEX: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.instr_done    = 1'b1;
            end
            ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ADDIWB:  begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
            JEX:     begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Outputs are registered from the state being entered, so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= ctrl_for(FETCH);
        end else begin
            state_q <= next_state(state_q, op);
            ctrl_q  <= ctrl_for(next_state(state_q, op));
        end
    end

    // Reset masks everything so no write strobe can leak out while it is held.
    assign PCWrite     = ctrl_q.pc_write      & ~reset;
    assign PCWriteCond = ctrl_q.pc_write_cond & ~reset;
    assign IorD        = ctrl_q.iord          & ~reset;
    assign MemRead     = ctrl_q.mem_read      & ~reset;
    assign MemWrite    = ctrl_q.mem_write     & ~reset;
    assign IRWrite     = ctrl_q.ir_write      & ~reset;
    assign MemtoReg    = ctrl_q.mem_to_reg    & ~reset;
    assign RegDst      = ctrl_q.reg_dst       & ~reset;
    assign RegWrite    = ctrl_q.reg_write     & ~reset;
    assign ALUSrcA     = ctrl_q.alu_src_a     & ~reset;
    assign ALUSrcB     = reset ? 2'b00 : ctrl_q.alu_src_b;
    assign ALUOp       = reset ? 2'b00 : ctrl_q.alu_op;
    assign PCSource    = reset ? 2'b00 : ctrl_q.pc_source;
    assign instr_done  = ctrl_q.instr_done    & ~reset;
    assign state       = reset ? 4'd0 : state_q;
    assign illegal_op  = ~reset & (state_q == DECODE) & ~is_legal(op);

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized instruction stream against a per-opcode model of state visits and
// per-state control words, plus reset and async-abort checks.
module tb_mips_mc_control;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic       clk, reset;
    logic [5:0] op;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic       instr_done, illegal_op;
    logic [15:0] obs_ctrl;

    int check_count = 0;
    int pass_count  = 0;
    int exp_seq[$];

    mips_mc_control dut (
        .clk(clk), .reset(reset), .op(op),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op)
    );

    assign obs_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    function automatic logic legal(input logic [5:0] opc);
        return opc inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

    function automatic logic writes_reg(input logic [5:0] opc);
        return opc inside {OP_RTYPE, OP_LW, OP_ADDI};
    endfunction

    // Control word per state code, in the same bit order as obs_ctrl.
    function automatic logic [15:0] exp_ctrl(input int st);
        logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, aop, pcs;
        {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            0:  begin mr = 1; irw = 1; asb = 2'b01; pw = 1; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
            9:  begin asa = 1; asb = 2'b10; end
            10: rw = 1;
            11: begin pw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs};
    endfunction

    task automatic build_sequence(input logic [5:0] opc);
        exp_seq = '{0, 1};
        case (opc)
            OP_LW:    begin exp_seq.push_back(2); exp_seq.push_back(3); exp_seq.push_back(4); end
            OP_SW:    begin exp_seq.push_back(2); exp_seq.push_back(5); end
            OP_RTYPE: begin exp_seq.push_back(6); exp_seq.push_back(7); end
            OP_BEQ:   exp_seq.push_back(8);
            OP_ADDI:  begin exp_seq.push_back(9); exp_seq.push_back(10); end
            OP_J:     exp_seq.push_back(11);
            default:  ;
        endcase
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput(tag, 32'({obs_ctrl, state, instr_done, illegal_op}), 32'd0);
    endtask

    // Runs one whole instruction starting in FETCH; called at a falling edge.
    task automatic applyStimulus(input logic [5:0] opc);
        int writes;
        int last;
        int st;
        writes = 0;
        build_sequence(opc);
        last = exp_seq.size() - 1;
        for (int i = 0; i <= last; i++) begin
            op = (i == 0) ? 6'($urandom_range(0, 63)) : opc;
            #1;
            st = exp_seq[i];
            checkOutput("state", 32'(state), 32'(st));
            checkOutput("ctrl", 32'(obs_ctrl), 32'(exp_ctrl(st)));
            checkOutput("instr_done", 32'(instr_done), 32'(i == last && legal(opc)));
            checkOutput("illegal_op", 32'(illegal_op), 32'(st == 1 && !legal(opc)));
            checkOutput("mr_mw_excl", 32'(MemRead & MemWrite), 32'd0);
            checkOutput("rw_mw_excl", 32'(RegWrite & MemWrite), 32'd0);
            writes += int'(RegWrite);
            @(negedge clk);
        end
        checkOutput("regwrite_count", 32'(writes), 32'(writes_reg(opc)));
    endtask

    initial begin
        logic [5:0] directed[7];
        logic [5:0] pick;
        directed = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, 6'b111111, OP_ADDI};
        reset = 1'b1;
        op    = 6'd0;
        repeat (3) begin
            @(negedge clk);
            op = 6'($urandom_range(0, 63));
            #1;
            check_all_zero("reset_hold");
        end
        @(negedge clk);
        reset = 1'b0;
        foreach (directed[i]) applyStimulus(directed[i]);

        // Abort a load in MEMRD with an asynchronous reset between clock edges.
        op = OP_LW;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("pre_abort_state", 32'(state), 32'd3);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        #1 check_all_zero("abort_hold");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(OP_LW);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0: pick = OP_RTYPE;
                1: pick = OP_LW;
                2: pick = OP_SW;
                3: pick = OP_BEQ;
                4: pick = OP_ADDI;
                5: pick = OP_J;
                default: pick = 6'($urandom_range(0, 63));
            endcase
            applyStimulus(pick);
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
